reg_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: the ALU result path and the memory/load result path.
Each requester pushes writes through a valid/ready handshake into its own small queue. A registered, starvation-limited priority arbiter drains the queues onto WRITE_REG/WRITE_DATA/REG_WRITE_ENABLE.
PENDING_MASK reports every register with a queued or in-flight write, so the hazard unit can stall issue.

---
 rtl/reg_write_arbiter_pkg.sv | 20 ++
 rtl/reg_write_arbiter_if.sv | 36 +++
 rtl/reg_write_arbiter_wb_fifo.sv | 75 +++++++
 rtl/reg_write_arbiter.sv | 119 +++++++++++
 tb/tb_reg_write_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter shared types: register address width, grant codes,
// and the queued writeback entry.
package reg_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam int WB_DATA_W = 64;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback bus: ALU/MEM valid-ready requests in, register-file write
// port and PENDING_MASK out. master = requesters/regfile, slave = arbiter.
interface reg_write_arbiter_if
  import reg_write_arbiter_pkg::*;
#(
  parameter int DATA_W = 64
);
  logic                  ALU_VALID;
  logic                  ALU_READY;
  logic [REG_ADDR_W-1:0] ALU_REG;
  logic [DATA_W-1:0]     ALU_DATA;
  logic                  MEM_VALID;
  logic                  MEM_READY;
  logic [REG_ADDR_W-1:0] MEM_REG;
  logic [DATA_W-1:0]     MEM_DATA;
  logic [REG_ADDR_W-1:0] WRITE_REG;
  logic [DATA_W-1:0]     WRITE_DATA;
  logic                  REG_WRITE_ENABLE;
  logic [31:0]           PENDING_MASK;

  modport master (
    output ALU_VALID, ALU_REG, ALU_DATA,
    output MEM_VALID, MEM_REG, MEM_DATA,
    input  ALU_READY, MEM_READY,
    input  WRITE_REG, WRITE_DATA,
    input  REG_WRITE_ENABLE, PENDING_MASK
  );

  modport slave (
    input  ALU_VALID, ALU_REG, ALU_DATA,
    input  MEM_VALID, MEM_REG, MEM_DATA,
    output ALU_READY, MEM_READY,
    output WRITE_REG, WRITE_DATA,
    output REG_WRITE_ENABLE, PENDING_MASK
  );
endinterface

// File: rtl/reg_write_arbiter_wb_fifo.sv
// wb_fifo: DEPTH-entry writeback queue. push/pop, head, empty/full,
// plus per-entry valid and dest reg for pending-mask generation.
module wb_fifo
  import reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push,
  input  logic [REG_ADDR_W-1:0]                push_rd,
  input  logic [DATA_W-1:0]                    push_data,
  input  logic                                 pop,
  output wb_entry_t                            head,
  output logic                                 empty,
  output logic                                 full,
  output logic [DEPTH-1:0]                     ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_rd
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic [DEPTH-1:0] vld_q;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign head    = mem_q[rd_ptr];
  assign ent_vld = vld_q;

  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem_q[i].rd;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr].rd   <= push_rd;
      mem_q[wr_ptr].data <= push_data;
    end
  end

  // push only when not full, pop only when not empty, so the two
  // valid-bit updates never hit the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        vld_q[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        vld_q[rd_ptr] <= 1'b0;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: two writeback queues (ALU, MEM) sharing one regfile
// write port; MEM-priority arbiter with ALU starvation limit; PENDING_MASK.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int DATA_W       = 64
) (
  input logic                 CLK,
  input logic                 RST_N,
  reg_write_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_entry_t                          a_head, m_head;
  logic                               a_empty, a_full;
  logic                               m_empty, m_full;
  logic [DEPTH-1:0]                   a_vld, m_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]   a_rd, m_rd;
  logic                               a_push, m_push;
  gnt_t                               gnt;
  logic [SW-1:0]                      starve_q;
  logic                               we_q;
  logic [REG_ADDR_W-1:0]              wreg_q;
  logic [DATA_W-1:0]                  wdata_q;
  logic                               alu_starved;

  assign bus.ALU_READY = !a_full;
  assign bus.MEM_READY = !m_full;

  // x0 writes complete the handshake but are never queued.
  assign a_push = bus.ALU_VALID && !a_full &&
                  (bus.ALU_REG != ZERO_REG);
  assign m_push = bus.MEM_VALID && !m_full &&
                  (bus.MEM_REG != ZERO_REG);

  assign alu_starved = !a_empty && (starve_q == STARVE_MAX);

  always_comb begin
    gnt = GNT_NONE;
    priority case (1'b1)
      (!m_empty && !alu_starved): gnt = GNT_MEM;
      (!a_empty):                 gnt = GNT_ALU;
      default:                    gnt = GNT_NONE;
    endcase
  end

  wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_alu_q (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (a_push),
    .push_rd   (bus.ALU_REG),
    .push_data (bus.ALU_DATA),
    .pop       (gnt == GNT_ALU),
    .head      (a_head),
    .empty     (a_empty),
    .full      (a_full),
    .ent_vld   (a_vld),
    .ent_rd    (a_rd)
  );

  wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem_q (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (m_push),
    .push_rd   (bus.MEM_REG),
    .push_data (bus.MEM_DATA),
    .pop       (gnt == GNT_MEM),
    .head      (m_head),
    .empty     (m_empty),
    .full      (m_full),
    .ent_vld   (m_vld),
    .ent_rd    (m_rd)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      unique case (gnt)
        GNT_ALU: begin
          we_q     <= 1'b1;
          wreg_q   <= a_head.rd;
          wdata_q  <= a_head.data;
          starve_q <= '0;
        end
        GNT_MEM: begin
          we_q    <= 1'b1;
          wreg_q  <= m_head.rd;
          wdata_q <= m_head.data;
          if (!a_empty && starve_q != STARVE_MAX) begin
            starve_q <= starve_q + 1'b1;
          end
        end
        default: we_q <= 1'b0;
      endcase
    end
  end

  assign bus.REG_WRITE_ENABLE = we_q;
  assign bus.WRITE_REG        = wreg_q;
  assign bus.WRITE_DATA       = wdata_q;

  always_comb begin
    bus.PENDING_MASK = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_vld[i]) bus.PENDING_MASK[a_rd[i]] = 1'b1;
      if (m_vld[i]) bus.PENDING_MASK[m_rd[i]] = 1'b1;
    end
    if (we_q) bus.PENDING_MASK[wreg_q] = 1'b1;
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed vectors, grant
// order, queue-full, x0, resets and random traffic vs a queue model.
module tb_reg_write_arbiter;

  localparam int DEPTH = 4;
  localparam int STARVE_LIMIT = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  reg_write_arbiter_if #(.DATA_W(64)) bus ();

  reg_write_arbiter #(
    .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DATA_W(64)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t        aq[$];
  ent_t        mq[$];
  int          mem_run;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [63:0] m_data;

  typedef struct {
    bit          av;
    logic [4:0]  ar;
    logic [63:0] ad;
    bit          mv;
    logic [4:0]  mr;
    logic [63:0] md;
    bit          ewe;
    logic [4:0]  ereg;
    logic [63:0] edata;
    logic [31:0] emask;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    mq.delete();
    mem_run = 0;
    m_we = 1'b0;
    m_reg = '0;
    m_data = '0;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (aq[i]) m[aq[i].rd] = 1'b1;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    if (m_we) m[m_reg] = 1'b1;
    return m;
  endfunction

  // One clock: drive, check readiness, advance model, check outputs.
  task automatic cycle(input bit av, input logic [4:0] ar,
                       input logic [63:0] ad, input bit mv,
                       input logic [4:0] mr, input logic [63:0] md);
    bit   acc_a, acc_m, mem_wins;
    ent_t e;
    bus.ALU_VALID = av;
    bus.ALU_REG   = ar;
    bus.ALU_DATA  = ad;
    bus.MEM_VALID = mv;
    bus.MEM_REG   = mr;
    bus.MEM_DATA  = md;
    chk("alu_ready", bus.ALU_READY, aq.size() < DEPTH);
    chk("mem_ready", bus.MEM_READY, mq.size() < DEPTH);
    acc_a = av && (aq.size() < DEPTH);
    acc_m = mv && (mq.size() < DEPTH);
    // MEM is preferred; a waiting ALU gets one turn after MEM has
    // won STARVE_LIMIT contested rounds in a row.
    mem_wins = (mq.size() > 0) &&
               !((aq.size() > 0) && (mem_run >= STARVE_LIMIT));
    if (mem_wins) begin
      e = mq.pop_front();
      m_we = 1'b1; m_reg = e.rd; m_data = e.data;
      if (aq.size() > 0) mem_run++;
    end else if (aq.size() > 0) begin
      e = aq.pop_front();
      m_we = 1'b1; m_reg = e.rd; m_data = e.data;
      mem_run = 0;
    end else begin
      m_we = 1'b0;
    end
    if (acc_a && ar != 5'd0) aq.push_back('{ar, ad});
    if (acc_m && mr != 5'd0) mq.push_back('{mr, md});
    @(posedge clk);
    #1;
    chk("we", bus.REG_WRITE_ENABLE, m_we);
    chk("wreg", bus.WRITE_REG, m_reg);
    chk("wdata", bus.WRITE_DATA, m_data);
    chk("mask", bus.PENDING_MASK, model_mask());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  got_reg[$];
    logic [63:0] got_dat[$];
    logic [4:0]  exp_ord[16];
    int          ai, mi, k;
    bit          ra, rm;
    bit          exp_rdy[5];

    // reset held with an ALU request pending
    rst_n = 1'b0;
    bus.ALU_VALID = 1'b1; bus.ALU_REG = 5'd3;
    bus.ALU_DATA = 64'h3333;
    bus.MEM_VALID = 1'b0; bus.MEM_REG = '0; bus.MEM_DATA = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", bus.REG_WRITE_ENABLE, 0);
    chk("rst_mask", bus.PENDING_MASK, 0);
    chk("rst_alu_ready", bus.ALU_READY, 1);
    chk("rst_mem_ready", bus.MEM_READY, 1);
    chk("rst_wreg", bus.WRITE_REG, 0);
    chk("rst_wdata", bus.WRITE_DATA, 0);
    rst_n = 1'b1;
    model_reset();
    cycle(1, 5'd3, 64'h3333, 0, 0, 0);
    chk("rst_first_mask", bus.PENDING_MASK, 32'h8);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_first_we", bus.REG_WRITE_ENABLE, 1);
    chk("rst_first_reg", bus.WRITE_REG, 3);

    // directed vectors, expected values derived by hand
    tbl[0] = '{1, 5,  64'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 32'h20};
    tbl[1] = '{0, 0,  0, 0, 0, 0, 1, 5, 64'hDEAD_BEEF, 32'h20};
    tbl[2] = '{0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0};
    tbl[3] = '{1, 0,  64'h1234, 0, 0, 0, 0, 0, 0, 32'h0};
    tbl[4] = '{0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0};
    tbl[5] = '{1, 8,  64'h88, 1, 7, 64'h77, 0, 0, 0, 32'h180};
    tbl[6] = '{0, 0,  0, 0, 0, 0, 1, 7, 64'h77, 32'h180};
    tbl[7] = '{0, 0,  0, 0, 0, 0, 1, 8, 64'h88, 32'h100};
    tbl[8] = '{0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].av, tbl[i].ar, tbl[i].ad,
            tbl[i].mv, tbl[i].mr, tbl[i].md);
      chk($sformatf("vec%0d_we", i), bus.REG_WRITE_ENABLE, tbl[i].ewe);
      chk($sformatf("vec%0d_mask", i), bus.PENDING_MASK, tbl[i].emask);
      if (tbl[i].ewe) begin
        chk($sformatf("vec%0d_reg", i), bus.WRITE_REG, tbl[i].ereg);
        chk($sformatf("vec%0d_data", i), bus.WRITE_DATA, tbl[i].edata);
      end
    end

    // both queues busy: MEM,MEM,MEM,ALU pattern, FIFO order per queue
    exp_ord = '{5'd9, 5'd10, 5'd11, 5'd1, 5'd12, 5'd13, 5'd14, 5'd2,
                5'd15, 5'd16, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    ai = 0; mi = 0;
    for (int c = 0; c < 40 && got_reg.size() < 16; c++) begin
      ra = bus.ALU_READY;
      rm = bus.MEM_READY;
      cycle(ai < 8, 5'(ai + 1), 64'hC0DE_0000 + 64'(ai + 1),
            mi < 8, 5'(mi + 9), 64'hC0DE_0000 + 64'(mi + 9));
      if (ai < 8 && ra) ai++;
      if (mi < 8 && rm) mi++;
      if (bus.REG_WRITE_ENABLE) begin
        got_reg.push_back(bus.WRITE_REG);
        got_dat.push_back(bus.WRITE_DATA);
      end
    end
    chk("gnt_count", got_reg.size(), 16);
    for (int i = 0; i < 16 && i < got_reg.size(); i++) begin
      chk($sformatf("gnt_order%0d", i), got_reg[i], exp_ord[i]);
      chk($sformatf("gnt_data%0d", i), got_dat[i],
          64'hC0DE_0000 + 64'(exp_ord[i]));
    end
    idle(3);

    // ALU queue fills while MEM owns the port
    exp_rdy = '{1, 1, 1, 0, 1};
    k = 0;
    for (int c = 0; c < 5; c++) begin
      ra = bus.ALU_READY;
      cycle(1, 5'(20 + k), 64'(20 + k), 1, 5'(24 + c), 64'(24 + c));
      if (ra) k++;
      chk($sformatf("full_ready%0d", c), bus.ALU_READY, exp_rdy[c]);
    end
    chk("full_accepts", k, 4);
    chk("full_pop_we", bus.REG_WRITE_ENABLE, 1);
    chk("full_pop_reg", bus.WRITE_REG, 20);
    idle(12);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 1), 5'($urandom_range(0, 31)),
            {$urandom, $urandom},
            $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            {$urandom, $urandom});
    end
    idle(12);

    // reset in the middle of a burst
    for (int c = 0; c < 4; c++) begin
      cycle(1, 5'(c + 1), 64'(c), 1, 5'(c + 10), 64'(c + 100));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", bus.REG_WRITE_ENABLE, 0);
    chk("mid_rst_mask", bus.PENDING_MASK, 0);
    chk("mid_rst_wreg", bus.WRITE_REG, 0);
    chk("mid_rst_wdata", bus.WRITE_DATA, 0);
    model_reset();
    bus.ALU_VALID = 1'b0;
    bus.MEM_VALID = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk("post_rst_we", bus.REG_WRITE_ENABLE, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
